lsu_misalign_seq: RTL and testbench
===================================

Name: lsu_misalign_seq

Overview:
- Load/store sequencer directly upstream of the data memory. It takes one load/store request at a time from the core and drives the memory port (write enable, byte address, write data, access mode).
- Aligned accesses go through as one memory beat.
- Misaligned halfword/word accesses are split into sequential byte beats. Load bytes are reassembled and sign/zero-extended, and the result is returned as a registered response.

Parameters:
- ADDR_WIDTH, 12, byte-address width of the memory port; address arithmetic wraps modulo 2^ADDR_WIDTH.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  core request present
- req_ready  out  1  sequencer can accept a request (high only in IDLE)
- req_we  in  1  1=store, 0=load
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  32  store data, LSB-aligned
- req_mode  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- resp_valid  out  1  one-cycle pulse: request complete
- resp_rdata  out  32  extended load data (0 for stores and errors)
- resp_err  out  1  valid with resp_valid: request rejected, no memory write done
- mem_write  out  1  memory write enable for current beat
- mem_addr  out  ADDR_WIDTH  memory byte address for current beat
- mem_wdata  out  32  memory write data (byte in [7:0] for split beats)
- mem_mode  out  3  memory access mode for current beat
- mem_rdata  in  32  combinational memory read data for mem_addr/mem_mode

Behaviour:
- Reset: state=IDLE, beat counter=0, byte buffer=0, resp_valid=0, resp_rdata=0, resp_err=0. mem_write is forced 0 while rst_n low. Reset mid-split abandons the request with no response; bytes already written stay written.
- States: IDLE, SPLIT.
- Request acceptance: accepted when req_valid && req_ready. req_ready = (state==IDLE).
- Size is mode[1:0] (00=1 byte, 01=2, 10=4). mode[1:0]==11 or mode==110/111 is invalid.
- Misalignment: size 2 with addr[0]=1, or size 4 with addr[1:0]!=0.
- Invalid mode: no memory beat (mem_write=0); next cycle resp_valid=1, resp_err=1, resp_rdata=0.
- Aligned request (IDLE, one beat): the memory port is driven combinationally from the request in the acceptance cycle (mem_mode=req_mode, mem_wdata=req_wdata). For loads, mem_rdata is registered. resp_valid pulses the next cycle. Latency is 1.
- Misaligned request:
  - Beat 0 happens in the acceptance cycle, from the request: address addr, mode 000.
  - Request fields are latched, then IDLE->SPLIT.
  - Beat i (i=1..N-1) uses address (addr+i) mod 2^ADDR_WIDTH, mem_mode=000, mem_wdata[7:0]=wdata byte i, other mem_wdata bits 0.
  - For loads, mem_rdata[7:0] of beat i goes into buffer byte i.
  - After beat N-1: SPLIT->IDLE, with resp_valid the next cycle.
  - Latency is N = 2 (half) or 4 (word).
- Load extension on split: H sign-extends bit 15, HU zero-extends, W none.
- Stores with mode BU/HU behave as B/H.
- resp_valid is a one-cycle pulse with no backpressure. A new request may be accepted in the same cycle resp_valid is high.
- Address wrap example: word at 0xFFE (ADDR_WIDTH=12) touches 0xFFE, 0xFFF, 0x000, 0x001.
- Outside an active beat: mem_write=0, mem_addr/mem_wdata/mem_mode don't-care but held stable (drive latched values).

Optional Feature:
- LSU_MISALIGN_TRAP_EN.
- Defined: misaligned requests are not split. No memory beat (mem_write=0), resp_valid next cycle with resp_err=1 and resp_rdata=0. SPLIT is never entered.
- Undefined: splitting as above; resp_err only for invalid modes.

Decomposition:
- Shared package dmem_pkg holds:
  - mode constants MODE_B=000, MODE_H=001, MODE_W=010, MODE_BU=100, MODE_HU=101
  - size-decode function
  - state enum {IDLE, SPLIT}
- The memory model imports the same mode constants.
- One sub-module: lsu_load_extend (combinational). Inputs: 32-bit raw bytes and mode. Output: extended 32-bit data. Used on the split path.

Test Plan:
- Aligned store W 0xDEADBEEF @0x010, then load W @0x010 -> single beat each, mem_mode=010, resp_valid 1 cycle later, rdata=0xDEADBEEF.
- Misaligned store W 0x11223344 @0x013 -> 4 beats with mem_addr 0x013..0x016, mem_wdata[7:0]=44,33,22,11, req_ready low 3 cycles. Then load W @0x013 -> rdata=0x11223344, resp 4 cycles after accept.
- Memory 0x021=0x80, 0x022=0xFF: load H @0x021 -> 0xFFFF_FF80; load HU @0x021 -> 0x0000_FF80.
- Word store 0xA1B2C3D4 @0xFFE -> writes 0xFFE=D4, 0xFFF=C3, 0x000=B2, 0x001=A1 (wrap).
- req_mode=011 -> no mem_write, resp_err=1, rdata=0. Separately, assert rst_n low during beat 2 of a split store -> no resp, req_ready=1 after reset, bytes 0-1 written only.
- With LSU_MISALIGN_TRAP_EN: load H @0x005 -> resp_err=1 after 1 cycle, mem_write never asserted, req_ready never drops.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared data-memory definitions: access-mode encodings, size decode,
// misalignment test and the load/store sequencer state type.
package dmem_pkg;

    // Access-mode encodings shared by the sequencer and the memory.
    localparam logic [2:0] MODE_B  = 3'b000;
    localparam logic [2:0] MODE_H  = 3'b001;
    localparam logic [2:0] MODE_W  = 3'b010;
    localparam logic [2:0] MODE_BU = 3'b100;
    localparam logic [2:0] MODE_HU = 3'b101;

    typedef enum logic {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } lsu_state_t;

    // Access size in bytes (1, 2 or 4); 0 flags an invalid mode.
    function automatic logic [2:0] mode_size(input logic [2:0] mode);
        case (mode)
            MODE_B, MODE_BU: mode_size = 3'd1;
            MODE_H, MODE_HU: mode_size = 3'd2;
            MODE_W:          mode_size = 3'd4;
            default:         mode_size = 3'd0;
        endcase
    endfunction

    // A halfword needs an even address, a word a multiple of four.
    function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
        is_misaligned = ((size == 3'd2) && addr_lo[0]) ||
                        ((size == 3'd4) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Combinational load extension: takes the reassembled little-endian bytes
// and sign- or zero-extends them according to the access mode.
module lsu_load_extend
    import dmem_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [2:0]  mode,
    output logic [31:0] data
);

    // Select the extension that matches the access width and signedness.
    always_comb begin
        case (mode)
            MODE_B:  data = {{24{raw[7]}}, raw[7:0]};
            MODE_BU: data = {24'h000000, raw[7:0]};
            MODE_H:  data = {{16{raw[15]}}, raw[15:0]};
            MODE_HU: data = {16'h0000, raw[15:0]};
            default: data = raw;
        endcase
    end

endmodule

// File: rtl/lsu_misalign_seq.sv
// Load/store sequencer in front of the data memory. Aligned accesses pass
// through as a single beat; misaligned halfword/word accesses are split into
// byte beats and loads are reassembled and extended.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned requests are rejected
// with resp_err instead of being split.
module lsu_misalign_seq
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [2:0]            req_mode,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [2:0]            mem_mode,
    input  logic [31:0]           mem_rdata
);

    lsu_state_t            state;
    logic [1:0]            beat_cnt;
    logic [31:0]           byte_buf;
    logic                  lat_we;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [31:0]           lat_wdata;
    logic [2:0]            lat_mode;
    logic [2:0]            lat_size;

    logic                  accept;
    logic [2:0]            req_size;
    logic                  req_trap;
    logic                  req_split;
    logic                  beat_last;
    logic [7:0]            beat_byte;
    logic [31:0]           buf_next;
    logic [31:0]           split_ext;

    assign req_ready = (state == IDLE);

    // Decode the incoming request and the current split beat.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        accept    = req_valid && (state == IDLE);
        req_size  = mode_size(req_mode);
`ifdef LSU_MISALIGN_TRAP_EN
        req_split = 1'b0;
        req_trap  = (req_size == 3'd0) || is_misaligned(req_size, req_addr[1:0]);
`else
        req_split = (req_size != 3'd0) && is_misaligned(req_size, req_addr[1:0]);
        req_trap  = (req_size == 3'd0);
`endif
        beat_last = ({1'b0, beat_cnt} == (lat_size - 3'd1));
        beat_byte = lat_wdata[7:0];
        buf_next  = byte_buf;
        case (beat_cnt)
            2'd0: begin beat_byte = lat_wdata[7:0];   buf_next[7:0]   = mem_rdata[7:0]; end
            2'd1: begin beat_byte = lat_wdata[15:8];  buf_next[15:8]  = mem_rdata[7:0]; end
            2'd2: begin beat_byte = lat_wdata[23:16]; buf_next[23:16] = mem_rdata[7:0]; end
            default: begin beat_byte = lat_wdata[31:24]; buf_next[31:24] = mem_rdata[7:0]; end
        endcase
    end

    // Extension of the reassembled bytes, including the byte of the final beat.
    lsu_load_extend u_load_extend (
        .raw  (buf_next),
        .mode (lat_mode),
        .data (split_ext)
    );

    // Drive the memory port: split beat, accepted request, or held latched values.
    always_comb begin
        mem_write = 1'b0;
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;
        mem_mode  = lat_mode;
        if (state == SPLIT) begin
            mem_write = lat_we;
            mem_addr  = lat_addr + ADDR_WIDTH'(beat_cnt);
            mem_wdata = {24'h000000, beat_byte};
            mem_mode  = MODE_B;
        end else if (accept && !req_trap) begin
            mem_write = req_we;
            mem_addr  = req_addr;
            if (req_split) begin
                mem_wdata = {24'h000000, req_wdata[7:0]};
                mem_mode  = MODE_B;
            end else begin
                mem_wdata = req_wdata;
                mem_mode  = req_mode;
            end
        end
        if (!rst_n) begin
            mem_write = 1'b0;
        end
    end

    // Sequencer FSM with registered response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: byte_buf is a handful of flops, not a RAM, so it is reset like any other state.
            state      <= IDLE;
            beat_cnt   <= 2'd0;
            byte_buf   <= 32'h0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= 32'h0;
            lat_mode   <= MODE_B;
            lat_size   <= 3'd0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_we    <= req_we;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_mode  <= req_mode;
                        lat_size  <= req_size;
                        if (req_trap) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0;
                        end else if (req_split) begin
                            state    <= SPLIT;
                            beat_cnt <= 2'd1;
                            byte_buf <= {24'h000000, (req_we ? 8'h00 : mem_rdata[7:0])};
                        end else begin
                            resp_valid <= 1'b1;
                            resp_rdata <= req_we ? 32'h0 : mem_rdata;
                        end
                    end
                end
                SPLIT: begin
                    if (!lat_we) begin
                        byte_buf <= buf_next;
                    end
                    if (beat_last) begin
                        state      <= IDLE;
                        beat_cnt   <= 2'd0;
                        resp_valid <= 1'b1;
                        resp_rdata <= lat_we ? 32'h0 : split_ext;
                    end else begin
                        beat_cnt <= beat_cnt + 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_misalign_seq.sv
// Self-checking bench for lsu_misalign_seq: byte-array memory model on the
// memory port, directed scenarios plus randomized requests checked against a
// byte-level reference model. Honors LSU_MISALIGN_TRAP_EN.
module tb_lsu_misalign_seq;
    import dmem_pkg::*;

    localparam int AW = 12;
    localparam int MEM_BYTES = 4096;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic [2:0]    req_mode;
    logic          resp_valid, resp_err;
    logic [31:0]   resp_rdata;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;
    logic [2:0]    mem_mode;

    always #5 clk = ~clk;

    lsu_misalign_seq #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_mode   (req_mode),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_mode   (mem_mode),
        .mem_rdata  (mem_rdata)
    );

    // ---------------- memory model on the DUT port ----------------
    logic [7:0]  mem [MEM_BYTES] = '{default: 8'h00};
    logic [31:0] mem_raw;

    always_comb begin
        mem_raw = {mem[mem_addr + 12'd3], mem[mem_addr + 12'd2],
                   mem[mem_addr + 12'd1], mem[mem_addr]};
        case (mem_mode)
            MODE_B:  mem_rdata = {{24{mem_raw[7]}}, mem_raw[7:0]};
            MODE_BU: mem_rdata = {24'h0, mem_raw[7:0]};
            MODE_H:  mem_rdata = {{16{mem_raw[15]}}, mem_raw[15:0]};
            MODE_HU: mem_rdata = {16'h0, mem_raw[15:0]};
            default: mem_rdata = mem_raw;
        endcase
    end

    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_addr] <= mem_wdata[7:0];
            if (mem_mode == MODE_H || mem_mode == MODE_HU || mem_mode == MODE_W)
                mem[mem_addr + 12'd1] <= mem_wdata[15:8];
            if (mem_mode == MODE_W) begin
                mem[mem_addr + 12'd2] <= mem_wdata[23:16];
                mem[mem_addr + 12'd3] <= mem_wdata[31:24];
            end
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [MEM_BYTES] = '{default: 8'h00};

    task automatic model(input logic we, input logic [AW-1:0] a, input logic [31:0] wd,
                         input logic [2:0] m, output logic [31:0] rd, output logic err,
                         output int lat, output int nbeats, output logic split, output int sz);
        logic [31:0] v;
        rd = 32'h0; err = 1'b0; lat = 1; nbeats = 0; split = 1'b0;
        sz = (m == 3'b000 || m == 3'b100) ? 1 :
             (m == 3'b001 || m == 3'b101) ? 2 :
             (m == 3'b010) ? 4 : 0;
        if (sz == 0) begin
            err = 1'b1;
            return;
        end
        if ((int'(a) % sz) != 0) begin
`ifdef LSU_MISALIGN_TRAP_EN
            err = 1'b1;
            return;
`else
            split = 1'b1;
            lat   = sz;
`endif
        end
        if (we) begin
            for (int i = 0; i < sz; i++) ref_mem[(int'(a) + i) % MEM_BYTES] = wd[8*i +: 8];
            nbeats = split ? sz : 1;
        end else begin
            v = 32'h0;
            for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_mem[(int'(a) + i) % MEM_BYTES];
            if (sz == 1)      rd = m[2] ? {24'h0, v[7:0]}  : {{24{v[7]}},  v[7:0]};
            else if (sz == 2) rd = m[2] ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
            else              rd = v;
        end
    endtask

    // ---------------- request driver / observer ----------------
    int            n_beats, ready_low, got_lat;
    logic          got_valid, got_err;
    logic [31:0]   got_rdata;
    logic [AW-1:0] beat_addr  [8];
    logic [31:0]   beat_wdata [8];
    logic [2:0]    beat_mode  [8];

    task automatic log_beat();
        if (mem_write) begin
            if (n_beats < 8) begin
                beat_addr[n_beats]  = mem_addr;
                beat_wdata[n_beats] = mem_wdata;
                beat_mode[n_beats]  = mem_mode;
            end
            n_beats++;
        end
    endtask

    task automatic do_req(input logic we, input logic [AW-1:0] a, input logic [31:0] wd,
                          input logic [2:0] m);
        int cyc;
        n_beats = 0; ready_low = 0; got_lat = 0; got_valid = 1'b0;
        got_err = 1'b0; got_rdata = 32'h0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_mode = m;
        #1;
        check("ready_at_accept", 32'(req_ready), 32'h1);
        log_beat();
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        cyc = 0;
        while (!got_valid && cyc < 12) begin
            @(negedge clk);
            cyc++;
            if (resp_valid) begin
                got_valid = 1'b1;
                got_rdata = resp_rdata;
                got_err   = resp_err;
                got_lat   = cyc;
            end else begin
                log_beat();
                if (!req_ready) ready_low++;
            end
        end
        check("resp_seen", 32'(got_valid), 32'h1);
        @(negedge clk);
        check("resp_pulse", 32'(resp_valid), 32'h0);
    endtask

    task automatic run_op(input logic we, input logic [AW-1:0] a, input logic [31:0] wd,
                          input logic [2:0] m);
        logic [31:0]   e_rd;
        logic          e_err, e_split;
        int            e_lat, e_beats, e_sz;
        logic [AW-1:0] ba;
        model(we, a, wd, m, e_rd, e_err, e_lat, e_beats, e_split, e_sz);
        do_req(we, a, wd, m);
        check("resp_err", 32'(got_err), 32'(e_err));
        check("resp_rdata", got_rdata, e_rd);
        check("latency", got_lat, e_lat);
        check("ready_low_cycles", ready_low, e_lat - 1);
        check("beat_count", n_beats, e_beats);
        for (int i = 0; i < n_beats && i < e_beats && i < 8; i++) begin
            ba = a + AW'(i);
            if (e_split) begin
                check("split_addr", 32'(beat_addr[i]), 32'(ba));
                check("split_wdata", beat_wdata[i], {24'h0, wd[8*i +: 8]});
                check("split_mode", 32'(beat_mode[i]), 32'(MODE_B));
            end else begin
                check("beat_addr", 32'(beat_addr[i]), 32'(a));
                check("beat_wdata", beat_wdata[i], wd);
                check("beat_mode", 32'(beat_mode[i]), 32'(m));
            end
        end
        if (we && !e_err) begin
            for (int i = 0; i < e_sz; i++) begin
                ba = a + AW'(i);
                check("mem_byte", 32'(mem[ba]), 32'(ref_mem[ba]));
            end
        end
    endtask

    // ---------------- stimulus ----------------
    logic [2:0] mode_pool [9] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101,
                                  3'b011, 3'b110, 3'b010, 3'b001};

    initial begin
        logic [AW-1:0] ra;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_wdata = 32'h0; req_mode = MODE_B;
        #1;
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_err", 32'(resp_err), 32'h0);
        check("rst_req_ready", 32'(req_ready), 32'h1);
        check("rst_mem_write", 32'(mem_write), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // aligned word store / load
        run_op(1'b1, 12'h010, 32'hDEADBEEF, MODE_W);
        run_op(1'b0, 12'h010, 32'h0, MODE_W);
        check("aligned_load_w", got_rdata, 32'hDEADBEEF);

        // misaligned word store / load
        run_op(1'b1, 12'h013, 32'h11223344, MODE_W);
        run_op(1'b0, 12'h013, 32'h0, MODE_W);
`ifndef LSU_MISALIGN_TRAP_EN
        check("split_load_w", got_rdata, 32'h11223344);
`endif

        // misaligned halfword sign / zero extension
        run_op(1'b1, 12'h021, 32'h00000080, MODE_B);
        run_op(1'b1, 12'h022, 32'h000000FF, MODE_BU);
        run_op(1'b0, 12'h021, 32'h0, MODE_H);
`ifndef LSU_MISALIGN_TRAP_EN
        check("split_load_h", got_rdata, 32'hFFFFFF80);
`endif
        run_op(1'b0, 12'h021, 32'h0, MODE_HU);
`ifndef LSU_MISALIGN_TRAP_EN
        check("split_load_hu", got_rdata, 32'h0000FF80);
`endif

        // address wrap
        run_op(1'b1, 12'hFFE, 32'hA1B2C3D4, MODE_W);
`ifndef LSU_MISALIGN_TRAP_EN
        check("wrap_ffe", 32'(mem[12'hFFE]), 32'hD4);
        check("wrap_fff", 32'(mem[12'hFFF]), 32'hC3);
        check("wrap_000", 32'(mem[12'h000]), 32'hB2);
        check("wrap_001", 32'(mem[12'h001]), 32'hA1);
`endif

        // invalid mode
        run_op(1'b1, 12'h030, 32'hCAFEF00D, 3'b011);
        check("invalid_err", 32'(got_err), 32'h1);
        check("invalid_no_write", n_beats, 0);

`ifdef LSU_MISALIGN_TRAP_EN
        // misaligned request trapped
        run_op(1'b0, 12'h005, 32'h0, MODE_H);
        check("trap_err", 32'(got_err), 32'h1);
        check("trap_latency", got_lat, 1);
        check("trap_no_write", n_beats, 0);
        check("trap_ready", ready_low, 0);
`else
        // reset during beat 2 of a split store
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 12'h041;
        req_wdata = 32'h55667788; req_mode = MODE_W;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_mem_write", 32'(mem_write), 32'h0);
        check("midrst_ready", 32'(req_ready), 32'h1);
        @(negedge clk);
        check("midrst_no_resp", 32'(resp_valid), 32'h0);
        rst_n = 1'b1;
        ref_mem[12'h041] = 8'h88;
        ref_mem[12'h042] = 8'h77;
        check("midrst_byte0", 32'(mem[12'h041]), 32'h88);
        check("midrst_byte1", 32'(mem[12'h042]), 32'h77);
        check("midrst_byte2", 32'(mem[12'h043]), 32'(ref_mem[12'h043]));
        check("midrst_byte3", 32'(mem[12'h044]), 32'(ref_mem[12'h044]));
        @(negedge clk);
        check("midrst_ready_after", 32'(req_ready), 32'h1);
`endif

        // randomized traffic in a low window and around the wrap point
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) ra = 12'hFF0 + AW'($urandom_range(0, 15));
            else                           ra = AW'($urandom_range(0, 31));
            run_op(1'($urandom_range(0, 1)), ra, $urandom, mode_pool[$urandom_range(0, 8)]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
